// File: rtl/mot_pkg.sv
// Shared types and constants for the four-channel motor PWM driver.
package mot_pkg;

    localparam int unsigned NUM_MOT = 4;
    localparam int unsigned DUTY_W  = 10;
    localparam int unsigned SET_W   = 16;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [SET_W-1:0]  mot_set_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2
    } arm_state_e;

    localparam duty_t DUTY_MAX = '1;

    // Setpoint to duty: keep the top DUTY_W bits of the 16-bit command.
    function automatic duty_t set_to_duty(input mot_set_t s);
        return s[SET_W-1 -: DUTY_W];
    endfunction

endpackage

// File: rtl/mot_slew.sv
// One motor channel: applied-duty register with slew limit, clamp and PWM compare.
module mot_slew
    import mot_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 16,
    parameter int unsigned MIN_DUTY  = 51
) (
    input  logic       clk,
    input  logic       reset,
    input  mot_set_t   mot_set,
    input  logic       boundary,
    input  arm_state_e state,
    input  arm_state_e state_nxt,
    input  duty_t      period_nxt,
    output logic       pwm_out
);

    localparam logic signed [10:0] STEP_S = 11'(SLEW_STEP);
    localparam duty_t              MIN_D  = duty_t'(MIN_DUTY);

    duty_t              applied;
    duty_t              applied_nxt;
    duty_t              target;
    duty_t              clamped;
    logic signed [10:0] diff;
    logic signed [10:0] slewed;
    logic               unused_low_bits;

    always_comb unused_low_bits = ^mot_set[SET_W-DUTY_W-1:0];

    // Slew toward the floored target in 11-bit signed arithmetic, then clamp.
    always_comb begin
        target = set_to_duty(mot_set);
        if (target < MIN_D) begin
            target = MIN_D;
        end
        diff = $signed({1'b0, target}) - $signed({1'b0, applied});
        if (diff > STEP_S) begin
            slewed = $signed({1'b0, applied}) + STEP_S;
        end else if (diff < -STEP_S) begin
            slewed = $signed({1'b0, applied}) - STEP_S;
        end else begin
            slewed = $signed({1'b0, target});
        end
        if (slewed < 11'sd0) begin
            clamped = '0;
        end else if (slewed > 11'sd1023) begin
            clamped = DUTY_MAX;
        end else begin
            clamped = slewed[DUTY_W-1:0];
        end
    end

    always_comb begin
        applied_nxt = applied;
        case (state_nxt)
            DISARMED: applied_nxt = '0;
            ARMING:   applied_nxt = MIN_D;
            ARMED: begin
                // The ARMING->ARMED boundary keeps MIN_DUTY; slewing starts one period later.
                if (boundary && (state == ARMED)) begin
                    applied_nxt = clamped;
                end
            end
            default:  applied_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            applied <= '0;
            pwm_out <= 1'b0;
        end else begin
            applied <= applied_nxt;
            pwm_out <= (state_nxt != DISARMED) && (period_nxt < applied_nxt);
        end
    end

endmodule

// File: rtl/mot_pwm.sv
// Four-channel motor PWM driver: prescaler, 1024-tick period counter, arm FSM
// and one slew/compare channel per motor.
module mot_pwm
    import mot_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50,
    parameter int unsigned SLEW_STEP   = 16,
    parameter int unsigned MIN_DUTY    = 51,
    parameter int unsigned ARM_PERIODS = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       kill,
    input  mot_set_t [NUM_MOT-1:0]     mot_set,
    output logic     [NUM_MOT-1:0]     pwm_out,
    output logic                       armed,
    output logic                       period_strobe
);

    localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned      AC_W    = $clog2(ARM_PERIODS + 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [AC_W-1:0]  AC_LAST = AC_W'(ARM_PERIODS - 1);

    logic [PS_W-1:0] presc;
    logic [PS_W-1:0] presc_nxt;
    duty_t           period_cnt;
    duty_t           period_nxt;
    logic            tick;
    logic            boundary;
    logic            disarm_req;
    arm_state_e      state;
    arm_state_e      state_nxt;
    logic [AC_W-1:0] arm_cnt;
    logic [AC_W-1:0] arm_cnt_nxt;

    always_comb begin
        tick       = (presc == PS_LAST);
        boundary   = tick && (period_cnt == DUTY_MAX);
        presc_nxt  = tick ? '0 : presc + PS_W'(1);
        period_nxt = tick ? period_cnt + duty_t'(1) : period_cnt;
        disarm_req = !arm || kill;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            period_cnt <= '0;
        end else begin
            presc      <= presc_nxt;
            period_cnt <= period_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DISARMED;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

    // Disarm takes effect on any clock; arming progress only at period boundaries.
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        case (state)
            DISARMED: begin
                arm_cnt_nxt = '0;
                if (boundary && arm && !kill) begin
                    state_nxt = ARMING;
                end
            end
            ARMING: begin
                if (disarm_req) begin
                    state_nxt   = DISARMED;
                    arm_cnt_nxt = '0;
                end else if (boundary) begin
                    if (arm_cnt == AC_LAST) begin
                        state_nxt   = ARMED;
                        arm_cnt_nxt = '0;
                    end else begin
                        arm_cnt_nxt = arm_cnt + AC_W'(1);
                    end
                end
            end
            ARMED: begin
                if (disarm_req) begin
                    state_nxt   = DISARMED;
                    arm_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = DISARMED;
                arm_cnt_nxt = '0;
            end
        endcase
    end

    // Status outputs registered from next-cycle values so they line up with the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed         <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            armed         <= (state_nxt == ARMED);
            period_strobe <= (presc_nxt == PS_LAST) && (period_nxt == DUTY_MAX);
        end
    end

    for (genvar g = 0; g < NUM_MOT; g++) begin : g_ch
        mot_slew #(
            .SLEW_STEP (SLEW_STEP),
            .MIN_DUTY  (MIN_DUTY)
        ) u_slew (
            .clk        (clk),
            .reset      (reset),
            .mot_set    (mot_set[g]),
            .boundary   (boundary),
            .state      (state),
            .state_nxt  (state_nxt),
            .period_nxt (period_nxt),
            .pwm_out    (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_mot_pwm.sv
// Bench for mot_pwm: period-level behavioural model checked every cycle, plus
// hand-computed high-time and latency expectations.
module tb_mot_pwm;
    import mot_pkg::*;

    localparam int P_SLEW = 64;
    localparam int P_MIN  = 51;
    localparam int P_ARM  = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  arm;
    logic                  kill;
    mot_set_t [3:0]        mot_set;
    logic     [3:0]        pwm_out;
    logic                  armed;
    logic                  period_strobe;

    always #5 clk = ~clk;

    mot_pwm #(
        .PRESCALE    (1),
        .SLEW_STEP   (P_SLEW),
        .MIN_DUTY    (P_MIN),
        .ARM_PERIODS (P_ARM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .kill          (kill),
        .mot_set       (mot_set),
        .pwm_out       (pwm_out),
        .armed         (armed),
        .period_strobe (period_strobe)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = off, 1 = arming, 2 = armed; m_pos is the tick within the period.
    int m_state;
    int m_pos;
    int m_arms;
    int m_duty[4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_pos   = 0;
            m_arms  = 0;
            for (int i = 0; i < 4; i++) m_duty[i] = 0;
        end else begin
            if (m_state != 0 && (!arm || kill)) begin
                m_state = 0;
                m_arms  = 0;
                for (int i = 0; i < 4; i++) m_duty[i] = 0;
            end else if (m_pos == 1023) begin
                if (m_state == 0) begin
                    if (arm && !kill) begin
                        m_state = 1;
                        m_arms  = 0;
                        for (int i = 0; i < 4; i++) m_duty[i] = P_MIN;
                    end
                end else if (m_state == 1) begin
                    m_arms++;
                    if (m_arms == P_ARM) m_state = 2;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        int tgt;
                        tgt = int'(mot_set[i]) / 64;
                        if (tgt < P_MIN) tgt = P_MIN;
                        if (tgt > m_duty[i] + P_SLEW)      m_duty[i] = m_duty[i] + P_SLEW;
                        else if (tgt + P_SLEW < m_duty[i]) m_duty[i] = m_duty[i] - P_SLEW;
                        else                               m_duty[i] = tgt;
                    end
                end
            end
            m_pos = (m_pos + 1) % 1024;
        end
    end

    // Per-cycle compare and per-period high-time bookkeeping.
    int         hi_cnt[4];
    int         hi_last[4];
    int         periods = 0;
    logic [3:0] exp_pwm;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) exp_pwm[i] = (m_state != 0) && (m_pos < m_duty[i]);
            check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
            check("armed", 32'(armed), 32'(m_state == 2));
            check("period_strobe", 32'(period_strobe), 32'(m_pos == 1023));
            for (int i = 0; i < 4; i++) if (pwm_out[i]) hi_cnt[i]++;
            if (period_strobe) begin
                for (int i = 0; i < 4; i++) begin
                    hi_last[i] = hi_cnt[i];
                    hi_cnt[i]  = 0;
                end
                periods++;
            end
        end
    end

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!period_strobe && n < 3000);
        if (!period_strobe) check({tag, " strobe timeout"}, 32'(period_strobe), 32'd1);
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (m_pos != p && n < 2000);
        if (m_pos != p) check("wait_pos timeout", 32'(m_pos), 32'(p));
    endtask

    task automatic check_all_hi(input string tag, input int exp);
        for (int i = 0; i < 4; i++) check(tag, 32'(hi_last[i]), 32'(exp));
    endtask

    int exp0[18] = '{51, 115, 179, 243, 307, 371, 435, 499, 563,
                     627, 691, 755, 819, 883, 947, 1011, 1023, 1023};
    int exp1[18] = '{51, 115, 128, 64, 51, 51, 51, 51, 51,
                     51, 51, 51, 51, 51, 51, 51, 51, 51};

    initial begin
        int n;
        reset   = 1'b1;
        arm     = 1'b0;
        kill    = 1'b0;
        mot_set = {4{16'hFFFF}};
        repeat (3) @(negedge clk);
        #1;
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset armed", 32'(armed), 32'd0);
        check("reset strobe", 32'(period_strobe), 32'd0);
        reset = 1'b0;

        // Disarmed with full command: nothing drives.
        repeat (4) wait_strobe("idle");
        check("idle periods", 32'(periods), 32'd4);
        check_all_hi("idle hi", 0);

        // Arm mid-period: arming starts at the next boundary.
        wait_pos(300);
        arm = 1'b1;
        wait_strobe("pre-arm");
        check_all_hi("pre-arm hi", 0);
        wait_strobe("arming1");
        check_all_hi("arming1 hi", 51);
        check("arming1 armed", 32'(armed), 32'd0);
        wait_strobe("arming2");
        check_all_hi("arming2 hi", 51);
        check("arming2 armed", 32'(armed), 32'd0);
        @(negedge clk);
        #1;
        check("armed after arming", 32'(armed), 32'd1);
        check("first armed pwm", 32'(pwm_out), 32'hF);

        // Slew up on ch0/ch2, short rise then floor decay on ch1, floor on ch3.
        mot_set = {16'h0000, 16'h8000, 16'h2000, 16'hFFC0};
        for (int k = 0; k < 18; k++) begin
            wait_strobe("slew");
            check("ch0 high time", 32'(hi_last[0]), 32'(exp0[k]));
            check("ch1 high time", 32'(hi_last[1]), 32'(exp1[k]));
            check("ch3 floor", 32'(hi_last[3]), 32'd51);
            if (k == 2) mot_set[1] = 16'h0000;
        end

        // Kill at period_cnt 500: duties 1023/51/512/51.
        wait_pos(500);
        check("pre-kill pwm", 32'(pwm_out), 32'h5);
        kill = 1'b1;
        @(negedge clk);
        #1;
        check("kill pwm", 32'(pwm_out), 32'd0);
        check("kill armed", 32'(armed), 32'd0);
        wait_strobe("kill1");
        wait_strobe("kill2");
        check_all_hi("kill held hi", 0);
        check("kill held armed", 32'(armed), 32'd0);
        kill = 1'b0;
        wait_strobe("rearm1");
        check_all_hi("rearm1 hi", 51);
        wait_strobe("rearm2");
        check_all_hi("rearm2 hi", 51);
        @(negedge clk);
        #1;
        check("rearmed", 32'(armed), 32'd1);

        // Asynchronous reset while outputs are high.
        wait_pos(20);
        check("pre-reset pwm", 32'(pwm_out), 32'hF);
        reset = 1'b1;
        #1;
        check("async reset pwm", 32'(pwm_out), 32'd0);
        check("async reset armed", 32'(armed), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!period_strobe && n < 2000);
        check("first strobe after reset", 32'(n), 32'd1023);

        // arm is still high: arming restarts, then arm drops on the completing boundary.
        wait_strobe("late1");
        check_all_hi("late arming1 hi", 51);
        wait_strobe("late2");
        check_all_hi("late arming2 hi", 51);
        arm = 1'b0;
        @(negedge clk);
        #1;
        check("disarm wins armed", 32'(armed), 32'd0);
        check("disarm wins pwm", 32'(pwm_out), 32'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
